mnist_frame_feeder: RTL and testbench
=====================================

# mnist_frame_feeder

Frame buffer and streamer sitting directly upstream of the `tt_um_rejunity_lgn_mnist` classifier. Accepts a binarised 28x28 image as a byte stream from a serial front end (UART receiver on the iCEBreaker), holds it in a local buffer, and on command replays it into the classifier's `ui_in` bus with a per-byte load strobe driven onto `uio_in[7]`. A held frame can be replayed any number of times, or cleared so a new one can be loaded.

## Interface
Parameters:
- `FRAME_BYTES`, 98, bytes per frame (784 pixels / 8); must be >= 2
- `SETTLE_CYCLES`, 2, idle cycles after the last byte before `done`; must be >= 1

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_data`  in  8  incoming frame byte; byte i holds pixels 8i..8i+7, bit0 = lowest pixel index
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  feeder accepts a byte this cycle
- `start`  in  1  replay request (level-sampled, one replay per accepted sample)
- `clear`  in  1  discard held frame, return to loading
- `ui_in`  out  8  byte to classifier `ui_in`
- `load`  out  1  byte strobe to classifier `uio_in[7]`
- `frame_ready`  out  1  complete frame held, feeder idle
- `busy`  out  1  replay in progress
- `done`  out  1  one-cycle pulse when a replay finishes

## Operation
- Storage: FRAME_BYTES x 8 array, write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(FRAME_BYTES) bits; pointers never wrap past FRAME_BYTES-1 (compare against FRAME_BYTES-1, reset to 0).
- State machine, four states:
  - FILL: `in_ready`=1. On `in_valid & in_ready` write `in_data` to buf[wr_ptr], increment `wr_ptr`. The accept at `wr_ptr == FRAME_BYTES-1` moves to FULL and resets `wr_ptr` to 0. `start` and `clear` are ignored.
  - FULL: `frame_ready`=1, `in_ready`=0. `clear`=1 moves to FILL (`wr_ptr`=0). `start`=1 (with `clear`=0) moves to STREAM, `rd_ptr`=0. If both are asserted, `clear` wins.
  - STREAM: `busy`=1. Drive buf[rd_ptr] with `load`=1 for exactly FRAME_BYTES consecutive cycles, in order 0..FRAME_BYTES-1. No stalls. `start`, `clear` and `in_valid` are ignored.
  - SETTLE: `busy`=1, `load`=0, `ui_in`=0 for SETTLE_CYCLES cycles. Then pulse `done` and return to FULL. The frame is retained for replay.
- `ui_in` is 0 whenever `load`=0.
- `in_ready` is combinational from state (FILL only). All other outputs are registered.
- Reset (`rst_n`=0 at a rising edge): state FILL, pointers 0, `load`/`ui_in`/`busy`/`done`/`frame_ready` = 0, `in_ready`=1 from the cycle after the reset edge. Buffer contents are not cleared. Reset mid-STREAM drops `load` at that same edge, with no `done`.

## Timing
- Let E0 be the edge where `start` is sampled in FULL. `busy`=1 from E0.
- `ui_in`=byte0 and `load`=1 are visible after E1. Byte k is visible after E(1+k). `load` falls after E(1+FRAME_BYTES).
- `done`=1 for the cycle after E(1+FRAME_BYTES+SETTLE_CYCLES). At that same edge `busy` falls and `frame_ready` rises.
- Replay cost: FRAME_BYTES + SETTLE_CYCLES + 1 cycles from `start` to `done`. Defaults: 98 + 2 + 1 = 101 cycles.
- Fill latency: `frame_ready` rises after the edge that accepts the last byte.
- Bytes offered while `in_ready`=0 are neither consumed nor buffered. The source must hold them.
- A `start` held high across `done` triggers a new replay at the first FULL cycle (back-to-back replay, one idle FULL cycle between replays).

## Test plan
- Reset then fill: after reset, send bytes 0x00..0x61 with `in_valid` held high. Required: 98 accepts, `in_ready` drops, `frame_ready`=1 after edge 98.
- Replay: `start` pulse in FULL. Required: `load`=1 for exactly 98 cycles, `ui_in` = 0x00..0x61 in order, `done` one cycle at start+101, `frame_ready` back to 1.
- Gated inputs: `start` during FILL and `in_valid` during STREAM. Required: no replay, buffer unchanged, second replay identical to the first.
- Clear priority: `start`=`clear`=1 in FULL. Required: FILL state, `load` never asserted, next 98 bytes (0xFF..0x9E) replay correctly.
- Reset mid-stream: `rst_n`=0 at byte 40 of a replay. Required: `load`=0 and `busy`=0 next cycle, no `done`, `in_ready`=1, `frame_ready`=0.
- Held `start` with FRAME_BYTES=2, SETTLE_CYCLES=1. Required: replays repeat every 5 cycles, each with two `load` cycles and one `done` pulse.

Source files
------------

// File: rtl/mnist_frame_feeder.sv
// mnist_frame_feeder: buffers one binarised 28x28 frame from a byte stream and
// replays it into the classifier ui_in bus with a per-byte load strobe.
// Revision: 1.0
`default_nettype none

module mnist_frame_feeder #(
  parameter int FRAME_BYTES   = 98,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       start_i,
  input  logic       clear_i,
  output logic [7:0] ui_in_o,
  output logic       load_o,
  output logic       frame_ready_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int PW = $clog2(FRAME_BYTES);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [PW-1:0] C_LAST_PTR   = PW'(FRAME_BYTES - 1);
  localparam logic [CW-1:0] C_SETTLE_END = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_FULL   = 2'd1,
    S_STREAM = 2'd2,
    S_SETTLE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   settle_q, settle_d;
  logic [7:0]      ui_in_q, ui_in_d;
  logic            load_q, load_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            frame_ready_q, frame_ready_d;
  logic [7:0]      mem_q [FRAME_BYTES];
  logic            wr_en;

  assign wr_en = (state_q == S_FILL) && in_valid_i;

  // Frame storage is deliberately left out of reset so a held frame costs no reset fan-out.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_FILL;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      settle_q      <= '0;
      ui_in_q       <= 8'h00;
      load_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      settle_q      <= settle_d;
      ui_in_q       <= ui_in_d;
      load_q        <= load_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      frame_ready_q <= frame_ready_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    settle_d      = settle_q;
    ui_in_d       = 8'h00;
    load_d        = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    frame_ready_d = 1'b0;
    case (state_q)
      S_FILL: begin
        if (in_valid_i) begin
          if (wr_ptr_q == C_LAST_PTR) begin
            wr_ptr_d      = '0;
            state_d       = S_FULL;
            frame_ready_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
        end
      end
      S_FULL: begin
        frame_ready_d = 1'b1;
        if (clear_i) begin
          state_d       = S_FILL;
          wr_ptr_d      = '0;
          frame_ready_d = 1'b0;
        end else if (start_i) begin
          state_d       = S_STREAM;
          rd_ptr_d      = '0;
          busy_d        = 1'b1;
          frame_ready_d = 1'b0;
        end
      end
      S_STREAM: begin
        busy_d  = 1'b1;
        load_d  = 1'b1;
        ui_in_d = mem_q[rd_ptr_q];
        if (rd_ptr_q == C_LAST_PTR) begin
          rd_ptr_d = '0;
          settle_d = '0;
          state_d  = S_SETTLE;
        end else begin
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
      end
      S_SETTLE: begin
        // The first SETTLE edge only drops load, so the exit comes one count later.
        if (settle_q == C_SETTLE_END) begin
          settle_d      = '0;
          done_d        = 1'b1;
          frame_ready_d = 1'b1;
          state_d       = S_FULL;
        end else begin
          busy_d   = 1'b1;
          settle_d = settle_q + CW'(1);
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  assign in_ready_o    = (state_q == S_FILL);
  assign ui_in_o       = ui_in_q;
  assign load_o        = load_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign frame_ready_o = frame_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_mnist_frame_feeder.sv
// Scoreboard bench for mnist_frame_feeder: default-size instance A and a
// FRAME_BYTES=2 / SETTLE_CYCLES=1 instance B for back-to-back replay.
`default_nettype none

module tb_mnist_frame_feeder;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Instance A (defaults)
  logic       a_rst_n, a_in_valid, a_in_ready, a_start, a_clear;
  logic [7:0] a_in_data, a_ui_in;
  logic       a_load, a_frame_ready, a_busy, a_done;

  mnist_frame_feeder u_dut_a (
    .clk          (clk),
    .rst_n        (a_rst_n),
    .in_data_i    (a_in_data),
    .in_valid_i   (a_in_valid),
    .in_ready_o   (a_in_ready),
    .start_i      (a_start),
    .clear_i      (a_clear),
    .ui_in_o      (a_ui_in),
    .load_o       (a_load),
    .frame_ready_o(a_frame_ready),
    .busy_o       (a_busy),
    .done_o       (a_done)
  );

  // Instance B (minimum sizes)
  logic       b_rst_n, b_in_valid, b_in_ready, b_start, b_clear;
  logic [7:0] b_in_data, b_ui_in;
  logic       b_load, b_frame_ready, b_busy, b_done;

  mnist_frame_feeder #(.FRAME_BYTES(2), .SETTLE_CYCLES(1)) u_dut_b (
    .clk          (clk),
    .rst_n        (b_rst_n),
    .in_data_i    (b_in_data),
    .in_valid_i   (b_in_valid),
    .in_ready_o   (b_in_ready),
    .start_i      (b_start),
    .clear_i      (b_clear),
    .ui_in_o      (b_ui_in),
    .load_o       (b_load),
    .frame_ready_o(b_frame_ready),
    .busy_o       (b_busy),
    .done_o       (b_done)
  );

  logic [7:0] model [98];
  logic [7:0] qa [$];
  logic [7:0] qb [$];

  // Monitors: every load cycle must match the next expected byte; idle ui_in must be 0.
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_load === 1'b1) begin
        chk("a_load_expected", (qa.size() != 0), 1);
        if (qa.size() != 0) chk("a_ui_in", a_ui_in, qa.pop_front());
      end else begin
        chk("a_ui_idle", a_ui_in, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (b_load === 1'b1) begin
        chk("b_load_expected", (qb.size() != 0), 1);
        if (qb.size() != 0) chk("b_ui_in", b_ui_in, qb.pop_front());
      end else begin
        chk("b_ui_idle", b_ui_in, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic fill_a(input bit descending, input bit start_noise);
    for (int i = 0; i < 98; i++) begin
      model[i]   = descending ? 8'(8'hFF - i) : 8'(i);
      a_in_valid = 1'b1;
      a_in_data  = model[i];
      a_start    = start_noise && (i >= 10) && (i <= 20);
      chk("a_fill_in_ready", a_in_ready, 1);
      chk("a_fill_frame_ready", a_frame_ready, 0);
      @(negedge clk);
    end
    a_start = 1'b0;
    // Source keeps offering a byte after the frame is full; it must not be taken.
    a_in_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      chk("a_full_in_ready", a_in_ready, 0);
      chk("a_full_frame_ready", a_frame_ready, 1);
      chk("a_full_busy", a_busy, 0);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
  endtask

  task automatic replay_a(input bit gated);
    int ld;
    int early;
    ld    = 0;
    early = 0;
    for (int i = 0; i < 98; i++) qa.push_back(model[i]);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("a_busy_at_e0", a_busy, 1);
    chk("a_fr_at_e0", a_frame_ready, 0);
    chk("a_load_at_e0", a_load, 0);
    if (gated) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'h5A;
      a_clear    = 1'b1;
      a_start    = 1'b1;
    end
    for (int n = 1; n <= 101; n++) begin
      @(negedge clk);
      if (a_load === 1'b1) ld++;
      if (n < 101 && a_done !== 1'b0) early++;
      if (n == 1)  chk("a_load_first", a_load, 1);
      if (n == 50) chk("a_stream_in_ready", a_in_ready, 0);
      if (n == 98) begin
        chk("a_load_last", a_load, 1);
        a_in_valid = 1'b0;
        a_clear    = 1'b0;
        a_start    = 1'b0;
      end
      if (n == 99) chk("a_load_fall", a_load, 0);
      if (n == 100) chk("a_settle_busy", a_busy, 1);
      if (n == 101) begin
        chk("a_done_pulse", a_done, 1);
        chk("a_busy_end", a_busy, 0);
        chk("a_fr_end", a_frame_ready, 1);
      end
    end
    chk("a_load_cycles", ld, 98);
    chk("a_early_done", early, 0);
    @(negedge clk);
    chk("a_done_one_cycle", a_done, 0);
    chk("a_fr_after", a_frame_ready, 1);
    chk("a_queue_drained", qa.size(), 0);
  endtask

  initial begin
    int dcnt;
    a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00; a_start = 1'b0; a_clear = 1'b0;
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00; b_start = 1'b0; b_clear = 1'b0;
    repeat (2) @(negedge clk);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    mon_en  = 1'b1;
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_load", a_load, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_frame_ready", a_frame_ready, 0);

    fill_a(1'b0, 1'b1);
    replay_a(1'b0);
    replay_a(1'b1);
    replay_a(1'b0);

    // start and clear together in FULL: clear wins
    a_start = 1'b1;
    a_clear = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_clear = 1'b0;
    chk("clr_in_ready", a_in_ready, 1);
    chk("clr_frame_ready", a_frame_ready, 0);
    chk("clr_busy", a_busy, 0);
    repeat (3) @(negedge clk);
    chk("clr_no_load", a_load, 0);
    fill_a(1'b1, 1'b0);
    replay_a(1'b0);

    // reset while byte 40 is on the bus
    for (int i = 0; i < 98; i++) qa.push_back(model[i]);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (41) @(negedge clk);
    chk("mid_load_before", a_load, 1);
    a_rst_n = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    qa.delete();
    chk("mid_load", a_load, 0);
    chk("mid_busy", a_busy, 0);
    chk("mid_done", a_done, 0);
    chk("mid_in_ready", a_in_ready, 1);
    chk("mid_frame_ready", a_frame_ready, 0);
    dcnt = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (a_done !== 1'b0) dcnt++;
    end
    chk("mid_no_done", dcnt, 0);

    // Instance B: held start gives a replay every 5 cycles
    b_in_valid = 1'b1;
    b_in_data  = 8'h3C;
    @(negedge clk);
    b_in_data  = 8'hC3;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("b_frame_ready", b_frame_ready, 1);
    chk("b_in_ready", b_in_ready, 0);
    for (int r = 0; r < 3; r++) begin
      qb.push_back(8'h3C);
      qb.push_back(8'hC3);
    end
    b_start = 1'b1;
    for (int n = 0; n <= 16; n++) begin
      @(negedge clk);
      chk("b_load", b_load, (n < 15) && ((n % 5 == 1) || (n % 5 == 2)));
      chk("b_done", b_done, (n < 15) && (n % 5 == 4));
      chk("b_busy", b_busy, (n < 15) && (n % 5 != 4));
      if (n == 10) b_start = 1'b0;
    end
    chk("b_queue_drained", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
